// File: rtl/reg_file_if.sv
// Bus bundle for reg_file: one byte-masked write port, two read ports and the write counter.
// Signal suffixes are from the register file's point of view.
interface reg_file_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic                 we_i;
    logic [ADDR_W-1:0]    waddr_i;
    logic [WIDTH-1:0]     wdata_i;
    logic [WIDTH/8-1:0]   wbyte_en_i;
    logic [ADDR_W-1:0]    raddr_a_i;
    logic [WIDTH-1:0]     rdata_a_o;
    logic [ADDR_W-1:0]    raddr_b_i;
    logic [WIDTH-1:0]     rdata_b_o;
    logic [15:0]          write_count_o;

    modport master (
        output we_i, waddr_i, wdata_i, wbyte_en_i, raddr_a_i, raddr_b_i,
        input  rdata_a_o, rdata_b_o, write_count_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, wbyte_en_i, raddr_a_i, raddr_b_i,
        output rdata_a_o, rdata_b_o, write_count_o
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: NUM_REGS x WIDTH registers, two combinational read ports, byte-masked write port.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      NUM_REGS  = 32,
    parameter int unsigned      ADDR_W    = 5,
    parameter bit               ZERO_REG  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic       clk_i,
    input logic       rst_n,
    reg_file_if.slave bus
);
    localparam int unsigned NumLanes = WIDTH / 8;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             commit;
    logic [15:0]      count_q, count_d;

    assign commit = bus.we_i && (|bus.wbyte_en_i) && !(ZERO_REG && (bus.waddr_i == '0));

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (ZERO_REG && (r == 0)) begin : g_zero
            assign regs[r] = '0;
        end else begin : g_store
            logic [NumLanes-1:0] lane_we;
            assign lane_we = (commit && (bus.waddr_i == ADDR_W'(r))) ? bus.wbyte_en_i : '0;
            for (genvar l = 0; l < NumLanes; l++) begin : g_lane
                logic [7:0] lane_q;
                always_ff @(posedge clk_i or negedge rst_n) begin
                    if (!rst_n) begin
                        lane_q <= RESET_VAL[8*l +: 8];
                    end else if (lane_we[l]) begin
                        lane_q <= bus.wdata_i[8*l +: 8];
                    end
                end
                assign regs[r][8*l +: 8] = lane_q;
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic [WIDTH-1:0] merged;

    // Value the write target will hold after the edge.
    always_comb begin
        merged = regs[bus.waddr_i];
        for (int l = 0; l < NumLanes; l++) begin
            if (bus.wbyte_en_i[l]) begin
                merged[8*l +: 8] = bus.wdata_i[8*l +: 8];
            end
        end
    end

    assign bus.rdata_a_o = (commit && (bus.raddr_a_i == bus.waddr_i)) ? merged
                                                                        : regs[bus.raddr_a_i];
    assign bus.rdata_b_o = (commit && (bus.raddr_b_i == bus.waddr_i)) ? merged
                                                                        : regs[bus.raddr_b_i];
`else
    assign bus.rdata_a_o = regs[bus.raddr_a_i];
    assign bus.rdata_b_o = regs[bus.raddr_b_i];
`endif

    always_comb begin
        count_d = count_q;
        if (commit && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.write_count_o = count_q;

    wr_ctl_known_a: assert property (@(posedge clk_i) disable iff (!rst_n)
                                     !$isunknown({bus.we_i, bus.waddr_i}));
endmodule
